// File: rtl/cache_controller_pkg.sv
// Shared definitions for the 2-way set-associative write-through cache:
// geometry (sets, index/tag widths), the byte base of the cached data region,
// and the controller FSM state encoding.
package cache_controller_pkg;

  localparam int          SETS        = 64;
  localparam int          INDEX_W     = $clog2(SETS);
  localparam int          TAG_W       = 17 - INDEX_W;
  localparam int          DATA_W      = 32;
  localparam logic [31:0] ADDR_OFFSET = 32'd1024;

  typedef enum logic [1:0] {
    CC_IDLE      = 2'd0,
    CC_READ_MISS = 2'd1,
    CC_WRITE     = 2'd2
  } cc_state_e;

endpackage

// File: rtl/cache_controller_if.sv
// Bus bundle between the MEM stage, the cache controller and SRAM_Controller.
//   mem_*  : requester side (rd/wr enables, address, write data, read data, ready)
//   sram_* : SRAM_Controller side (rd/wr request, address, data, ready strobe)
// Modport slave is the cache; modport master is the surrounding system
// (MEM stage plus SRAM_Controller).
interface cache_controller_if;
  import cache_controller_pkg::*;

  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              sram_rd_en;
  logic              sram_wr_en;
  logic [31:0]       sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_ready;

  modport slave (
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    output sram_rd_en, sram_wr_en, sram_addr, sram_wdata,
    input  sram_rdata, sram_ready
  );

  modport master (
    output mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    input  sram_rd_en, sram_wr_en, sram_addr, sram_wdata,
    output sram_rdata, sram_ready
  );

endinterface

// File: rtl/cache_storage.sv
// Tag/data storage for the 2-way cache, held in flops.
//   index, tag   : lookup key for the current request
//   hit, hit_way, hit_data : combinational lookup result
//   victim       : way to fill on a miss (first invalid way, way0 first, else lru)
//   fill_en      : write tag/fill_data into victim, mark valid, point lru away from it
//   update_en    : on a hit, overwrite the hit way's data and point lru away from it
//   touch_en     : on a hit, point lru away from the hit way
// rst clears all valid bits and lru bits; tags and data need no reset.
module cache_storage
  import cache_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  output logic               hit,
  output logic               hit_way,
  output logic [DATA_W-1:0]  hit_data,
  output logic               victim,
  input  logic               fill_en,
  input  logic [DATA_W-1:0]  fill_data,
  input  logic               update_en,
  input  logic [DATA_W-1:0]  update_data,
  input  logic               touch_en
);

  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [DATA_W-1:0] data_q  [2][SETS];

  // A line is written into at most one way, so at most one way matches.
  always_comb begin
    hit      = 1'b0;
    hit_way  = 1'b0;
    hit_data = '0;
    for (int w = 0; w < 2; w++) begin
      if (valid_q[w][index] && (tag_q[w][index] == tag)) begin
        hit      = 1'b1;
        hit_way  = w[0];
        hit_data = data_q[w][index];
      end
    end
    victim = lru_q[index];
    if (!valid_q[0][index])      victim = 1'b0;
    else if (!valid_q[1][index]) victim = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else if (fill_en) begin
      valid_q[victim][index] <= 1'b1;
      lru_q[index]           <= ~victim;
    end else if ((update_en || touch_en) && hit) begin
      lru_q[index] <= ~hit_way;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[victim][index]  <= tag;
      data_q[victim][index] <= fill_data;
    end else if (update_en && hit) begin
      data_q[hit_way][index] <= update_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, read-allocate cache between the MEM
// stage and SRAM_Controller. Read hits complete in the request cycle; read
// misses and all writes are sequenced onto the SRAM req/ready handshake, and
// mem_ready stays low (freezing the pipeline) until SRAM_Controller finishes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cache_controller_if.slave (mem_* requester side, sram_* memory side)
module cache_controller
  import cache_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  cache_controller_if.slave  bus
);

  logic [16:0]        word;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;

  logic               hit;
  logic               hit_way;
  logic [DATA_W-1:0]  hit_data;
  logic               victim;
  logic               fill_en;
  logic               update_en;
  logic               touch_en;

  cc_state_e          state;
  cc_state_e          state_nxt;

  // Addresses below the region base wrap modulo 2^32 and alias into the cache.
  assign word  = 17'((bus.mem_addr - ADDR_OFFSET) >> 2);
  assign index = word[INDEX_W-1:0];
  assign tag   = word[16:INDEX_W];

  assign bus.sram_addr  = bus.mem_addr;
  assign bus.sram_wdata = bus.mem_wdata;

  cache_storage u_storage (
    .clk         (clk),
    .rst         (rst),
    .index       (index),
    .tag         (tag),
    .hit         (hit),
    .hit_way     (hit_way),
    .hit_data    (hit_data),
    .victim      (victim),
    .fill_en     (fill_en),
    .fill_data   (bus.sram_rdata),
    .update_en   (update_en),
    .update_data (bus.mem_wdata),
    .touch_en    (touch_en)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= CC_IDLE;
    else     state <= state_nxt;
  end

  // The SRAM enables are decoded from the state, so they fall at the same
  // edge the FSM returns to IDLE and SRAM_Controller never sees a second
  // request. sram_ready is only looked at while a request is outstanding.
  always_comb begin
    state_nxt      = state;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;
    bus.sram_rd_en = 1'b0;
    bus.sram_wr_en = 1'b0;
    fill_en        = 1'b0;
    update_en      = 1'b0;
    touch_en       = 1'b0;
    case (state)
      CC_IDLE: begin
        if (bus.mem_wr_en) begin
          state_nxt = CC_WRITE;
        end else if (bus.mem_rd_en && !hit) begin
          state_nxt = CC_READ_MISS;
        end else begin
          bus.mem_ready = 1'b1;
          if (bus.mem_rd_en) begin
            bus.mem_rdata = hit_data;
            touch_en      = 1'b1;
          end
        end
      end
      CC_READ_MISS: begin
        bus.sram_rd_en = 1'b1;
        if (bus.sram_ready) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = bus.sram_rdata;
          fill_en       = 1'b1;
          state_nxt     = CC_IDLE;
        end
      end
      CC_WRITE: begin
        bus.sram_wr_en = 1'b1;
        if (bus.sram_ready) begin
          bus.mem_ready = 1'b1;
          update_en     = 1'b1;
          state_nxt     = CC_IDLE;
        end
      end
      default: state_nxt = CC_IDLE;
    endcase
    // Reset abandons any in-flight access and holds the requester stalled.
    if (rst) begin
      state_nxt      = CC_IDLE;
      bus.mem_ready  = 1'b0;
      bus.mem_rdata  = '0;
      bus.sram_rd_en = 1'b0;
      bus.sram_wr_en = 1'b0;
      fill_en        = 1'b0;
      update_en      = 1'b0;
      touch_en       = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Testbench for cache_controller: an SRAM_Controller model with random latency,
// a recency-list reference model of the cache plus a memory image, directed
// scenarios with literal expectations and a randomized request stream.
module tb_cache_controller;
  import cache_controller_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_controller_if bus();

  cache_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Initial SRAM contents: a recognisable function of the address.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA55A, ~a[15:0]};
  endfunction

  // ---------------- SRAM_Controller model ----------------
  logic [31:0] sram_mem [logic [31:0]];
  int          sram_acc = 0;
  bit          busy;
  int          lat;
  logic [31:0] last_addr, last_wdata;
  bit          last_is_wr;

  initial begin
    bus.sram_ready = 1'b0;
    bus.sram_rdata = '0;
    busy = 0;
    lat  = 0;
    last_addr = '0;
    last_wdata = '0;
    last_is_wr = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy = 0;
        bus.sram_ready = 1'b0;
      end else if (bus.sram_ready) begin
        bus.sram_ready = 1'b0;
        busy = 0;
      end else if (bus.sram_rd_en || bus.sram_wr_en) begin
        if (!busy) begin
          busy       = 1;
          sram_acc++;
          lat        = $urandom_range(0, 3);
          last_addr  = bus.sram_addr;
          last_wdata = bus.sram_wdata;
          last_is_wr = bus.sram_wr_en;
        end
        if (lat == 0) begin
          bus.sram_ready = 1'b1;
          if (last_is_wr) sram_mem[last_addr] = last_wdata;
          else bus.sram_rdata = sram_mem.exists(last_addr) ? sram_mem[last_addr]
                                                           : init_word(last_addr);
        end else begin
          lat--;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Each set is a recency list of resident tags, most recent first, at most two long.
  int          rlist [SETS][2];
  int          rcnt  [SETS];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic int addr_idx(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'd1024) / 4;
    return int'(w % SETS);
  endfunction

  function automatic int addr_tag(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'd1024) / 4;
    return int'((w / SETS) % (1 << TAG_W));
  endfunction

  function automatic int ref_find(input int idx, input int tg);
    for (int i = 0; i < rcnt[idx]; i++)
      if (rlist[idx][i] == tg) return i;
    return -1;
  endfunction

  function automatic void ref_touch(input int idx, input int pos);
    int t;
    if (pos == 1) begin
      t = rlist[idx][1];
      rlist[idx][1] = rlist[idx][0];
      rlist[idx][0] = t;
    end
  endfunction

  function automatic void ref_fill(input int idx, input int tg);
    rlist[idx][1] = rlist[idx][0];
    rlist[idx][0] = tg;
    if (rcnt[idx] < 2) rcnt[idx]++;
  endfunction

  function automatic void ref_clear();
    for (int i = 0; i < SETS; i++) rcnt[i] = 0;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // ---------------- request driver + per-cycle compare ----------------
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, output bit obs_hit,
                       output logic [31:0] obs_data);
    int idx, tg, pos, acc0, cyc;
    bit exp_hit, done;
    logic [31:0] exp_d;
    idx = addr_idx(addr);
    tg  = addr_tag(addr);
    pos = ref_find(idx, tg);
    exp_hit  = rd && !wr && (pos >= 0);
    exp_d    = ref_read(addr);
    obs_hit  = 0;
    obs_data = '0;
    done = 0;
    cyc  = 0;
    @(negedge clk);
    bus.mem_rd_en = rd;
    bus.mem_wr_en = wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = wd;
    acc0 = sram_acc;
    while (!done && cyc < 20) begin
      #2;
      if (cyc == 0 && rd && !wr) obs_hit = bus.mem_ready;
      if (exp_hit) begin
        chk("hit ready", 32'(bus.mem_ready), 32'd1);
        chk("hit data", bus.mem_rdata, exp_d);
        chk("hit no sram", 32'({bus.sram_rd_en, bus.sram_wr_en}), 32'd0);
        obs_data = bus.mem_rdata;
        done = 1;
      end else if (cyc == 0) begin
        chk("entry stall", 32'(bus.mem_ready), 32'd0);
        chk("entry sram idle", 32'({bus.sram_rd_en, bus.sram_wr_en}), 32'd0);
      end else begin
        chk("sram_rd_en", 32'(bus.sram_rd_en), 32'(!wr));
        chk("sram_wr_en", 32'(bus.sram_wr_en), 32'(wr));
        chk("ready vs sram_ready", 32'(bus.mem_ready), 32'(bus.sram_ready));
        chk("sram_addr", bus.sram_addr, addr);
        if (bus.mem_ready) begin
          if (!wr) begin
            chk("miss data", bus.mem_rdata, exp_d);
            obs_data = bus.mem_rdata;
          end
          done = 1;
        end
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    chk("sram access count", 32'(sram_acc - acc0), exp_hit ? 32'd0 : 32'd1);
    if (wr) begin
      chk("sram write addr", last_addr, addr);
      chk("sram write data", last_wdata, wd);
      ref_mem[addr] = wd;
      if (pos >= 0) ref_touch(idx, pos);
    end else if (rd) begin
      if (pos >= 0) ref_touch(idx, pos);
      else          ref_fill(idx, tg);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.mem_rd_en = 1'b0;
    bus.mem_wr_en = 1'b0;
    #2;
    chk("idle ready", 32'(bus.mem_ready), 32'd1);
    chk("idle sram", 32'({bus.sram_rd_en, bus.sram_wr_en}), 32'd0);
  endtask

  bit          h;
  logic [31:0] d;

  initial begin
    bus.mem_rd_en = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    ref_clear();

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst mem_rdata", bus.mem_rdata, 32'd0);
    chk("rst sram_en", 32'({bus.sram_rd_en, bus.sram_wr_en}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("post-rst idle ready", 32'(bus.mem_ready), 32'd1);

    // Miss then hit on 0x400
    do_op(1, 0, 32'h400, 0, h, d);
    chk("0x400 first miss", 32'(h), 32'd0);
    chk("0x400 fill data", d, init_word(32'h400));
    do_op(1, 0, 32'h400, 0, h, d);
    chk("0x400 second hit", 32'(h), 32'd1);

    // LRU eviction in set 0: 0x400, 0x500, 0x600 share index 0
    do_op(1, 0, 32'h500, 0, h, d);
    chk("0x500 miss", 32'(h), 32'd0);
    do_op(1, 0, 32'h400, 0, h, d);
    chk("0x400 hit", 32'(h), 32'd1);
    do_op(1, 0, 32'h600, 0, h, d);
    chk("0x600 miss", 32'(h), 32'd0);
    do_op(1, 0, 32'h400, 0, h, d);
    chk("0x400 kept", 32'(h), 32'd1);
    do_op(1, 0, 32'h500, 0, h, d);
    chk("0x500 evicted", 32'(h), 32'd0);

    // Write-through hit updates cached data
    do_op(0, 1, 32'h400, 32'hDEADBEEF, h, d);
    do_op(1, 0, 32'h400, 0, h, d);
    chk("0x400 hit after write", 32'(h), 32'd1);
    chk("0x400 written data", d, 32'hDEADBEEF);

    // Write miss allocates nothing
    do_op(0, 1, 32'h800, 32'h12345678, h, d);
    do_op(1, 0, 32'h800, 0, h, d);
    chk("0x800 miss after write", 32'(h), 32'd0);
    chk("0x800 data from sram", d, 32'h12345678);

    // Both enables: write path only
    do_op(1, 1, 32'h404, 32'hCAFEF00D, h, d);
    idle_cycle();

    // Reset during a read miss
    do_op(1, 0, 32'h404, 0, h, d);
    do_op(1, 0, 32'h404, 0, h, d);
    chk("0x404 cached", 32'(h), 32'd1);
    @(negedge clk);
    bus.mem_rd_en = 1'b1;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = 32'h504;
    @(negedge clk);
    #2;
    chk("mid-miss sram_rd_en", 32'(bus.sram_rd_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid-miss rst ready", 32'(bus.mem_ready), 32'd0);
    chk("mid-miss rst rdata", bus.mem_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rd_en = 1'b0;
    #2;
    chk("after rst sram_rd_en", 32'(bus.sram_rd_en), 32'd0);
    chk("after rst ready", 32'(bus.mem_ready), 32'd1);
    ref_clear();
    do_op(1, 0, 32'h404, 0, h, d);
    chk("0x404 lost by rst", 32'(h), 32'd0);
    chk("0x404 data", d, 32'hCAFEF00D);

    // Randomized stream over a small conflicting address pool
    for (int n = 0; n < 300; n++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 7);
      a   = 32'h400 + ((32'($urandom_range(0, 3)) * SETS + 32'($urandom_range(0, 3))) << 2);
      if (sel < 4)       do_op(1, 0, a, 32'($urandom), h, d);
      else if (sel < 6)  do_op(0, 1, a, 32'($urandom), h, d);
      else if (sel == 6) do_op(1, 1, a, 32'($urandom), h, d);
      else               idle_cycle();
    end

    idle_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
